registrador_sipo: RTL and testbench

- Serial-in, parallel-out receiver that deserializes a framed serial bit stream into WIDTH-bit words.
- Counterpart of the team's 4-bit PISO transmitter, and sits at the far end of the same serial link.
- Has a shift stage and a separate output holding register, so reception continues while the previous word waits for the consumer.
- The consumer accepts words through a valid/ready handshake.

---
 rtl/registrador_sipo.sv | 100 ++++++++++
 tb/tb_registrador_sipo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/registrador_sipo.sv
// Serial-in, parallel-out receiver: assembles framed serial bits into WIDTH-bit words
// and hands them to a consumer through a valid/ready holding register.
module registrador_sipo #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     serial_in,
    input  logic                     frame_start,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun,
    output logic                     frame_error
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] parallel_reg;
    logic [CW-1:0]    count_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             overrun_reg;
    logic             frame_error_reg;

    logic             capture;
    logic             last_bit;
    logic [CW-1:0]    pos_next;
    logic [CW-1:0]    idx_next;
    logic [WIDTH-1:0] base_word;
    logic [WIDTH-1:0] word_next;

    // A frame_start bit always begins a fresh word, so it overlays an empty word at position 0.
    assign capture   = enable && (frame_start || state_reg == RECV);
    assign last_bit  = capture && !frame_start && (count_reg == CW'(WIDTH - 1));
    assign pos_next  = frame_start ? '0 : count_reg;
    assign idx_next  = LSB_FIRST ? pos_next : (CW'(WIDTH - 1) - pos_next);
    assign base_word = frame_start ? '0 : shift_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_insert
            assign word_next[gi] = (idx_next == CW'(gi)) ? serial_in : base_word[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            parallel_reg    <= '0;
            count_reg       <= '0;
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            overrun_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
            if (valid_reg && out_ready) begin
                valid_reg <= 1'b0;
            end
            if (capture) begin
                shift_reg <= word_next;
                if (frame_start) begin
                    frame_error_reg <= (state_reg == RECV);
                    count_reg       <= CW'(1);
                    state_reg       <= RECV;
                    busy_reg        <= 1'b1;
                end else if (last_bit) begin
                    count_reg <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    // Holding register is free if empty or being drained on this same edge.
                    if (!valid_reg || out_ready) begin
                        parallel_reg <= word_next;
                        valid_reg    <= 1'b1;
                    end else begin
                        overrun_reg <= 1'b1;
                    end
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end
        end
    end

    assign parallel_out = parallel_reg;
    assign out_valid    = valid_reg;
    assign busy         = busy_reg;
    assign bit_count    = count_reg;
    assign overrun      = overrun_reg;
    assign frame_error  = frame_error_reg;
endmodule

// File: tb/tb_registrador_sipo.sv
// Scoreboard bench: LSB-first and MSB-first receivers share one stimulus stream;
// expected words are queued at issue time and popped by a monitor on each transfer.
module tb_registrador_sipo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       serial_in = 1'b0;
    logic       frame_start = 1'b0;
    logic       out_ready = 1'b0;

    logic [3:0] l_parallel_out, m_parallel_out;
    logic       l_out_valid, m_out_valid;
    logic       l_busy, m_busy;
    logic [1:0] l_bit_count, m_bit_count;
    logic       l_overrun, m_overrun;
    logic       l_frame_error, m_frame_error;

    int vectors = 0;
    int miscompares = 0;
    int ovr_seen = 0;
    int fe_seen = 0;
    logic [3:0] q_l[$];
    logic [3:0] q_m[$];

    registrador_sipo #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .enable(enable), .serial_in(serial_in),
        .frame_start(frame_start), .out_ready(out_ready),
        .parallel_out(l_parallel_out), .out_valid(l_out_valid), .busy(l_busy),
        .bit_count(l_bit_count), .overrun(l_overrun), .frame_error(l_frame_error)
    );

    registrador_sipo #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .serial_in(serial_in),
        .frame_start(frame_start), .out_ready(out_ready),
        .parallel_out(m_parallel_out), .out_valid(m_out_valid), .busy(m_busy),
        .bit_count(m_bit_count), .overrun(m_overrun), .frame_error(m_frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Monitor: a transfer happens on the coming edge when valid and ready are both high.
    always @(negedge clk) begin
        if (l_overrun) ovr_seen++;
        if (l_frame_error) fe_seen++;
        if (l_out_valid && out_ready) begin
            if (q_l.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_lsb_unexpected: got %0h, expected no word", l_parallel_out);
            end else begin
                check("sb_lsb_word", l_parallel_out, q_l.pop_front());
            end
        end
        if (m_out_valid && out_ready) begin
            if (q_m.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_msb_unexpected: got %0h, expected no word", m_parallel_out);
            end else begin
                check("sb_msb_word", m_parallel_out, q_m.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[i] is the i-th bit on the wire; gap idle cycles follow each non-final bit.
    task automatic send_word(input logic [3:0] seq, input int gap, input logic rdy_last);
        for (int i = 0; i < 4; i++) begin
            enable      = 1'b1;
            frame_start = (i == 0);
            serial_in   = seq[i];
            if (i == 3) out_ready = rdy_last;
            tick();
            enable      = 1'b0;
            frame_start = 1'b0;
            if (i < 3) begin
                check("bit_count", l_bit_count, i + 1);
                check("busy", l_busy, 1);
                for (int g = 0; g < gap; g++) begin
                    serial_in = ~serial_in;
                    tick();
                    check("bit_count_hold", l_bit_count, i + 1);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with toggling inputs
        for (int i = 0; i < 3; i++) begin
            enable      = ~enable;
            serial_in   = ~serial_in;
            frame_start = i[0];
            tick();
        end
        check("rst_parallel_out", l_parallel_out, 0);
        check("rst_out_valid", l_out_valid, 0);
        check("rst_busy", l_busy, 0);
        check("rst_bit_count", l_bit_count, 0);
        check("rst_overrun", l_overrun, 0);
        check("rst_frame_error", l_frame_error, 0);
        check("rst_msb_valid", m_out_valid, 0);
        enable = 1'b0; frame_start = 1'b0; serial_in = 1'b0;
        reset = 1'b1;
        tick();

        // Basic word 1,0,1,1
        out_ready = 1'b0;
        q_l.push_back(4'hD); q_m.push_back(4'hB);
        send_word(4'b1101, 0, 1'b0);
        check("basic_valid", l_out_valid, 1);
        check("basic_lsb_word", l_parallel_out, 4'hD);
        check("basic_msb_word", m_parallel_out, 4'hB);
        check("basic_busy_idle", l_busy, 0);
        check("basic_count_wrap", l_bit_count, 0);
        out_ready = 1'b1;
        tick();
        check("basic_valid_clear", l_out_valid, 0);

        // Gapped input, consumer always ready
        q_l.push_back(4'hD); q_m.push_back(4'hB);
        send_word(4'b1101, 2, 1'b1);
        check("gap_valid", l_out_valid, 1);
        check("gap_lsb_word", l_parallel_out, 4'hD);
        check("gap_msb_word", m_parallel_out, 4'hB);
        tick();
        check("gap_valid_clear", l_out_valid, 0);

        // Overrun: second word dropped while the first is unconsumed
        out_ready = 1'b0;
        q_l.push_back(4'hD); q_m.push_back(4'hB);
        send_word(4'b1101, 0, 1'b0);
        check("ovr_first_no_pulse", l_overrun, 0);
        send_word(4'b0110, 0, 1'b0);
        check("ovr_pulse", l_overrun, 1);
        check("ovr_no_frame_error", l_frame_error, 0);
        check("ovr_word_held", l_parallel_out, 4'hD);
        check("ovr_valid_held", l_out_valid, 1);
        tick();
        check("ovr_pulse_end", l_overrun, 0);
        check("ovr_word_stable", l_parallel_out, 4'hD);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_clear", l_out_valid, 0);

        // Accept old word on the same edge a new one completes
        out_ready = 1'b0;
        q_l.push_back(4'hD); q_m.push_back(4'hB);
        q_l.push_back(4'h3); q_m.push_back(4'hC);
        send_word(4'b1101, 0, 1'b0);
        send_word(4'b0011, 0, 1'b1);
        check("simul_no_overrun", l_overrun, 0);
        check("simul_valid", l_out_valid, 1);
        check("simul_lsb_word", l_parallel_out, 4'h3);
        check("simul_msb_word", m_parallel_out, 4'hC);
        tick();
        check("simul_valid_clear", l_out_valid, 0);

        // Frame abort after two bits
        check("fe_none_before", fe_seen, 0);
        q_l.push_back(4'h7); q_m.push_back(4'hE);
        enable = 1'b1; frame_start = 1'b1; serial_in = 1'b0;
        tick();
        frame_start = 1'b0; serial_in = 1'b1;
        tick();
        check("fe_partial_count", l_bit_count, 2);
        send_word(4'b0111, 0, 1'b1);
        check("fe_lsb_word", l_parallel_out, 4'h7);
        tick();

        // Asynchronous reset mid-frame
        q_l.push_back(4'h9); q_m.push_back(4'h9);
        enable = 1'b1; frame_start = 1'b1; serial_in = 1'b1;
        tick();
        frame_start = 1'b0; serial_in = 1'b0;
        tick();
        serial_in = 1'b1;
        tick();
        enable = 1'b0;
        check("arst_pre_count", l_bit_count, 3);
        #2 reset = 1'b0;
        #1;
        check("arst_bit_count", l_bit_count, 0);
        check("arst_busy", l_busy, 0);
        check("arst_lsb_word", l_parallel_out, 0);
        check("arst_msb_word", m_parallel_out, 0);
        tick();
        reset = 1'b1;
        tick();
        send_word(4'b1001, 0, 1'b1);
        check("arst_new_word", l_parallel_out, 4'h9);
        tick();
        tick();

        check("end_queue_lsb", q_l.size(), 0);
        check("end_queue_msb", q_m.size(), 0);
        check("end_overrun_pulses", ovr_seen, 1);
        check("end_frame_error_pulses", fe_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
